cpu_phase_gen: RTL and testbench
================================

# cpu_phase_gen

Parametrised instruction-phase generator for the simple CPU. It divides each instruction into `NPHASE` clock phases and produces the `fetch` and `alu_ena` strobes over programmable phase windows. It adds behaviour the fixed 8-state generator lacks:

- run/halt control
- single-step
- wait-state stall
- cycle-end pulse
- retired-instruction counter

It sits between the system clock/reset and the CPU's fetch, ALU and control units.

## Interface
Parameters:
- `NPHASE`, 8, phases per instruction cycle (≥2)
- `PW`, `$clog2(NPHASE)`, width of `phase` output
- `ALU_START`, 1, first phase with `alu_ena`=1
- `ALU_LEN`, 1, number of phases with `alu_ena`=1 (0 = never)
- `FETCH_START`, 3, first phase with `fetch`=1
- `FETCH_LEN`, 4, number of phases with `fetch`=1 (0 = never)
- `CW`, 16, width of `instr_cnt`

Ports:
- `clk`  in  1  clock; all state updates on the falling edge
- `reset`  in  1  reset, synchronous, active-high
- `run`  in  1  1 = execute cycles continuously; 0 = halt at the next cycle boundary
- `step`  in  1  in IDLE with `run`=0, starts exactly one cycle
- `stall`  in  1  in ACTIVE, freezes phase and strobes (memory wait state)
- `phase`  out  `PW`  current phase index
- `fetch`  out  1  fetch strobe
- `alu_ena`  out  1  ALU enable strobe
- `cycle_end`  out  1  one-clock pulse on cycle completion
- `busy`  out  1  1 while in ACTIVE
- `instr_cnt`  out  `CW`  completed cycles, modulo 2^`CW`

## Operation
- Window rule: `win(p, S, L)` = (p ≥ S) && (p < S+L). The elaboration check fails if S+L > `NPHASE` or `NPHASE` < 2.
- `fetch` = `win(phase, FETCH_START, FETCH_LEN)` and `alu_ena` = `win(phase, ALU_START, ALU_LEN)`. Both are registered and update on the same edge as `phase`; no combinational path from inputs to outputs.
- Reset (priority over everything, any state): state=IDLE, `phase`=0, `fetch`=0, `alu_ena`=0, `cycle_end`=0, `busy`=0, `instr_cnt`=0.
- Two states: IDLE and ACTIVE.
- IDLE:
  - `phase`=0, strobes=0, `busy`=0, and `stall` is ignored.
  - If `run`=1, or `step`=1 with `run`=0: go to ACTIVE with `phase`←0, strobes←win(0), `busy`←1. One mode latch records "single" when entry was by `step` alone.
- ACTIVE, `stall`=1: `phase`, strobes and `instr_cnt` hold; `cycle_end`←0.
- ACTIVE, `stall`=0, `phase`<`NPHASE`-1: `phase`←`phase`+1 and strobes←win(`phase`+1).
- ACTIVE, `stall`=0, `phase`=`NPHASE`-1 (wrap):
  - `cycle_end`←1 for one clock and `instr_cnt`←`instr_cnt`+1 (wraps to 0 at 2^`CW`-1).
  - If `run`=1 and mode≠single: stay ACTIVE, `phase`←0, strobes←win(0).
  - Otherwise: go to IDLE, `phase`←0, strobes←0, `busy`←0.
- Halt is boundary-only: `run` falling mid-cycle never truncates the cycle. `run` rising during a single-step cycle does not extend it; the next cycle starts from IDLE.
- `step` is ignored in ACTIVE and ignored when `run`=1.
- `stall` at the wrap phase delays the wrap, `cycle_end` and the counter increment until `stall`=0.

## Timing
- Start latency: one falling edge from sampling `run`/`step` in IDLE to `phase`=0 with `busy`=1.
- An unstalled cycle occupies exactly `NPHASE` clocks in ACTIVE.
- With continuous run there are no idle clocks between cycles; phase 0 follows phase `NPHASE`-1 directly.
- With defaults: `alu_ena` is high during phase 1 only; `fetch` is high during phases 3–6; `cycle_end` is high during the clock following phase 7.
- Each stall clock extends the cycle by one clock at the stalled phase.
- Stop: IDLE is reached on the same edge that raises `cycle_end` when halting. Restart is possible on the next edge, giving a minimum one IDLE clock between halted cycles.

## Test plan
- Reset, then `run`=1 held for 3 cycles (defaults): `phase` sequence 0..7 repeated; `alu_ena` high only at phase 1; `fetch` high at phases 3–6; `cycle_end` pulses 3 times, 8 clocks apart; `instr_cnt`=3.
- `run` dropped at phase 2 of cycle 2: cycle completes through phase 7; `cycle_end` pulses; IDLE with `busy`=0 and strobes 0; `instr_cnt`=2.
- `run`=0 with a `step` pulse: exactly one 8-phase cycle; `instr_cnt`=1, then IDLE. Extra `step` pulses during ACTIVE are ignored.
- `stall`=1 for 3 clocks at phase 4: `phase` holds at 4 with `fetch`=1 for 4 clocks total; cycle length 11 clocks. `stall` at phase 7 delays `cycle_end` by the stall length.
- `reset` asserted at phase 5 with `run`=1: next edge gives all outputs at reset values and state IDLE. Releasing `reset` with `run`=1 gives `phase`=0 one edge later.
- `NPHASE`=5, `ALU_START`=0, `ALU_LEN`=2, `FETCH_LEN`=0, `CW`=2, run 5 cycles: `alu_ena` high at phases 0–1; `fetch` never high; `instr_cnt` sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/cpu_phase_gen.sv
// cpu_phase_gen: instruction-phase sequencer with programmable fetch/ALU windows,
// run/halt, single-step, wait-state stall, cycle-end pulse and retired-cycle counter.
module cpu_phase_gen #(
    parameter int NPHASE      = 8,
    parameter int PW          = $clog2(NPHASE),
    parameter int ALU_START   = 1,
    parameter int ALU_LEN     = 1,
    parameter int FETCH_START = 3,
    parameter int FETCH_LEN   = 4,
    parameter int CW          = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic          step,
    input  logic          stall,
    output logic [PW-1:0] phase,
    output logic          fetch,
    output logic          alu_ena,
    output logic          cycle_end,
    output logic          busy,
    output logic [CW-1:0] instr_cnt
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    if (NPHASE < 2 || ALU_START + ALU_LEN > NPHASE || FETCH_START + FETCH_LEN > NPHASE) begin : g_param_check
        $error("cpu_phase_gen: phase windows must fit inside NPHASE >= 2");
    end

    function automatic logic win(input logic [PW-1:0] p, input int s, input int l);
        return int'(p) >= s && int'(p) < s + l;
    endfunction

    logic [0:0]    state_q, state_d;
    logic          single_q, single_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          fetch_q, fetch_d;
    logic          alu_q, alu_d;
    logic          cycle_end_q, cycle_end_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wrap;
    logic          cont;
    logic [PW-1:0] phase_inc;

    assign wrap      = phase_q == PW'(NPHASE - 1);
    assign phase_inc = phase_q + 1'b1;
    // back-to-back cycles only in free-run mode; a single step always returns to IDLE
    assign cont      = run && !single_q;

    always_comb begin
        state_d     = state_q;
        single_d    = single_q;
        phase_d     = phase_q;
        fetch_d     = fetch_q;
        alu_d       = alu_q;
        cycle_end_d = 1'b0;
        cnt_d       = cnt_q;
        if (state_q == IDLE) begin
            if (run || step) begin
                state_d  = ACTIVE;
                single_d = !run;
                phase_d  = '0;
                fetch_d  = win('0, FETCH_START, FETCH_LEN);
                alu_d    = win('0, ALU_START, ALU_LEN);
            end
        end else if (!stall) begin
            if (!wrap) begin
                phase_d = phase_inc;
                fetch_d = win(phase_inc, FETCH_START, FETCH_LEN);
                alu_d   = win(phase_inc, ALU_START, ALU_LEN);
            end else begin
                cycle_end_d = 1'b1;
                cnt_d       = cnt_q + 1'b1;
                phase_d     = '0;
                state_d     = cont ? ACTIVE : IDLE;
                fetch_d     = cont && win('0, FETCH_START, FETCH_LEN);
                alu_d       = cont && win('0, ALU_START, ALU_LEN);
            end
        end
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            single_q    <= 1'b0;
            phase_q     <= '0;
            fetch_q     <= 1'b0;
            alu_q       <= 1'b0;
            cycle_end_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            single_q    <= single_d;
            phase_q     <= phase_d;
            fetch_q     <= fetch_d;
            alu_q       <= alu_d;
            cycle_end_q <= cycle_end_d;
            cnt_q       <= cnt_d;
        end
    end

    assign phase     = phase_q;
    assign fetch     = fetch_q;
    assign alu_ena   = alu_q;
    assign cycle_end = cycle_end_q;
    assign busy      = state_q == ACTIVE;
    assign instr_cnt = cnt_q;
endmodule

// File: tb/tb_cpu_phase_gen.sv
// tb_cpu_phase_gen: drives a default and a 5-phase instance with directed and random
// run/step/stall/reset and compares every output against a cycle-level reference model.
module tb_cpu_phase_gen;
    logic clk = 1'b0;
    logic reset = 1'b1, run = 1'b0, step = 1'b0, stall = 1'b0;
    logic [2:0]  phase_a, phase_b;
    logic        fetch_a, alu_a, ce_a, busy_a;
    logic        fetch_b, alu_b, ce_b, busy_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cpu_phase_gen u_def (
        .clk(clk), .reset(reset), .run(run), .step(step), .stall(stall),
        .phase(phase_a), .fetch(fetch_a), .alu_ena(alu_a), .cycle_end(ce_a),
        .busy(busy_a), .instr_cnt(cnt_a)
    );

    cpu_phase_gen #(.NPHASE(5), .ALU_START(0), .ALU_LEN(2), .FETCH_LEN(0), .CW(2)) u_small (
        .clk(clk), .reset(reset), .run(run), .step(step), .stall(stall),
        .phase(phase_b), .fetch(fetch_b), .alu_ena(alu_b), .cycle_end(ce_b),
        .busy(busy_b), .instr_cnt(cnt_b)
    );

    // model configuration and state, index 0 = default instance, 1 = small instance
    int np[2]  = '{8, 5};
    int as_[2] = '{1, 0};
    int al[2]  = '{1, 2};
    int fs[2]  = '{3, 3};
    int fl[2]  = '{4, 0};
    int cw[2]  = '{16, 2};
    int act[2], ph[2], sgl[2], cnt[2], ce[2];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int in_win(int p, int s, int l);
        return (p >= s && p < s + l) ? 1 : 0;
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                act[k] = 0; ph[k] = 0; sgl[k] = 0; cnt[k] = 0; ce[k] = 0;
            end else if (!act[k]) begin
                ce[k] = 0;
                if (run || step) begin
                    act[k] = 1; ph[k] = 0; sgl[k] = run ? 0 : 1;
                end
            end else if (stall) begin
                ce[k] = 0;
            end else if (ph[k] < np[k] - 1) begin
                ph[k]++; ce[k] = 0;
            end else begin
                ce[k] = 1;
                cnt[k] = (cnt[k] + 1) % (1 << cw[k]);
                ph[k] = 0;
                act[k] = (run && !sgl[k]) ? 1 : 0;
            end
        end
    endtask

    task automatic compare_all();
        check("def.phase", int'(phase_a), ph[0]);
        check("def.fetch", int'(fetch_a), act[0] * in_win(ph[0], fs[0], fl[0]));
        check("def.alu_ena", int'(alu_a), act[0] * in_win(ph[0], as_[0], al[0]));
        check("def.cycle_end", int'(ce_a), ce[0]);
        check("def.busy", int'(busy_a), act[0]);
        check("def.instr_cnt", int'(cnt_a), cnt[0]);
        check("small.phase", int'(phase_b), ph[1]);
        check("small.fetch", int'(fetch_b), act[1] * in_win(ph[1], fs[1], fl[1]));
        check("small.alu_ena", int'(alu_b), act[1] * in_win(ph[1], as_[1], al[1]));
        check("small.cycle_end", int'(ce_b), ce[1]);
        check("small.busy", int'(busy_b), act[1]);
        check("small.instr_cnt", int'(cnt_b), cnt[1]);
    endtask

    // inputs change just after a rising edge; DUT and model advance on the falling edge
    task automatic cyc(input logic r, input logic rn, input logic st, input logic sl);
        reset = r; run = rn; step = st; stall = sl;
        @(negedge clk);
        model_step();
        @(posedge clk);
        compare_all();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            act[k] = 0; ph[k] = 0; sgl[k] = 0; cnt[k] = 0; ce[k] = 0;
        end
        @(posedge clk);
        repeat (2) cyc(1, 0, 0, 0);
        repeat (25) cyc(0, 1, 0, 0);
        check("def.cnt_after_3_cycles", int'(cnt_a), 3);
        repeat (11) cyc(0, 1, 0, 0);
        repeat (12) cyc(0, 0, 0, 0);
        check("def.idle_after_halt", int'(busy_a), 0);
        cyc(0, 0, 1, 0);
        repeat (3) cyc(0, 0, 1, 0);
        repeat (2) cyc(0, 1, 0, 0);
        repeat (8) cyc(0, 0, 0, 0);
        check("def.idle_after_step", int'(busy_a), 0);
        repeat (2) cyc(1, 0, 0, 0);
        repeat (5) cyc(0, 1, 0, 0);
        repeat (3) cyc(0, 1, 0, 1);
        repeat (10) cyc(0, 1, 0, 0);
        repeat (4) cyc(0, 1, 0, 1);
        repeat (6) cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        check("def.reset_busy", int'(busy_a), 0);
        check("def.reset_cnt", int'(cnt_a), 0);
        repeat (12) cyc(0, 1, 0, 0);
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 63) == 0, $urandom_range(0, 9) < 7,
                $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
